rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the issued-write counter.
REQ-002 The block SHALL have parameter ZERO_PROTECT, default 1: when 1, writes to register 0 are acknowledged but never issued.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset: port clock, input, 1 bit, rising-edge clock; port ctrl_reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port rf_stall, input, 1 bit: register file unavailable; block all grants.
REQ-005 The block SHALL have requester A ports:
- a_req, input, 1 bit: write request.
- a_addr, input, 5 bits: destination register.
- a_data, input, 32 bits: write data.
- a_ack, output, 1 bit: request accepted this cycle.
REQ-006 The block SHALL have requester B ports b_req, b_addr, b_data and b_ack, with the same directions, widths and meanings as requester A.
REQ-007 The block SHALL have port wr_en, output, 32 bits: one-hot register write enable to the register file.
REQ-008 The block SHALL have port wr_data, output, 32 bits: data for the enabled register.
REQ-009 The block SHALL have port wr_count, output, CNT_W bits: count of issued writes.

Function
REQ-010 a_ack and b_ack SHALL be combinational, and at most one of them SHALL be high in any cycle.
REQ-011 When rf_stall=1, both acks SHALL be 0 and no grant SHALL occur.
REQ-012 With one requester active and no stall, that requester SHALL be acked in the same cycle.
REQ-013 With both requesters active and no stall, the grant SHALL follow a 2-state round-robin pointer:
- PRI_A: grant A.
- PRI_B: grant B.
REQ-014 After a grant to A the pointer SHALL move to PRI_B; after a grant to B it SHALL move to PRI_A; with no grant the pointer SHALL hold.
REQ-015 A requester SHALL hold req, addr and data stable until acked; dropping req before ack is a legal withdrawal and SHALL have no side effects.
REQ-016 Issue latency SHALL be 1 cycle: on the clock edge following an ack, wr_en SHALL become the one-hot decode of the granted addr (bit addr=1, all others 0), and wr_data SHALL become the granted data.
REQ-017 If ZERO_PROTECT=1 and the granted addr=0, wr_en SHALL be all-zero in the issue cycle and wr_data SHALL still update.
REQ-018 In cycles with no issue, wr_en SHALL be all-zero and wr_data SHALL hold its last value.
REQ-019 wr_en SHALL never have more than one bit set.
REQ-020 wr_count SHALL increment by 1 in each cycle in which wr_en is non-zero, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-021 Back-to-back grants SHALL be sustained: one write issued per cycle with no bubbles while requests are present and there is no stall.
REQ-022 Both requesters targeting the same address in the same cycle SHALL be resolved by round-robin only; the loser is acked on a later cycle, so the later write wins in the register file.
REQ-023 rf_stall rising in the cycle after an ack SHALL NOT cancel the already-registered issue.

Reset
REQ-024 On ctrl_reset=1, asynchronously: wr_en=0, wr_data=0, wr_count=0, pointer=PRI_A.
REQ-025 Acks SHALL be forced to 0 while ctrl_reset=1.
REQ-026 Reset mid-operation SHALL discard a write registered but not yet seen by the register file; requesters SHALL re-request after reset.

Structure
REQ-027 The shared package SHALL hold the pointer state encodings PRI_A/PRI_B, the register address width (5), the data width (32) and the register count (32).
REQ-028 The combinational round-robin grant logic SHALL be one sub-module, rf_wr_rr_pick (inputs: two reqs, stall, pointer; outputs: two grants); the one-hot decode and all state SHALL live in rf_write_arbiter.

Verification
REQ-029 Only A requests, addr=5, data=0xDEADBEEF -> a_ack=1 same cycle; next cycle wr_en=0x00000020, wr_data=0xDEADBEEF, wr_count=1.
REQ-030 A and B request continuously from reset for 4 cycles -> acks A,B,A,B; wr_en issued each cycle with no gaps.
REQ-031 B requests addr=0, data=0x1234 with ZERO_PROTECT=1 -> b_ack=1; next cycle wr_en=0, wr_data=0x1234, wr_count unchanged.
REQ-032 Both request while rf_stall=1 for 3 cycles, then rf_stall drops -> no acks and wr_en=0 during the stall; the first ack after the stall follows the pointer state held during the stall.
REQ-033 With CNT_W=4, 16 writes to addr=31 -> wr_count wraps to 0; wr_en=0x80000000 on each issue.
REQ-034 Assert ctrl_reset between the ack edge and the next edge -> wr_en=0 immediately, wr_count=0, pointer=PRI_A; no write is issued after reset is released.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and round-robin pointer encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rf_wr_rr_pick.sv
// Combinational two-way round-robin pick; a lone requester always wins, ties follow ptr_i.
module rf_wr_rr_pick
  import rf_write_arbiter_pkg::*;
(
  input  logic    a_req_i,
  input  logic    b_req_i,
  input  logic    stall_i,
  input  rr_ptr_e ptr_i,
  output logic    a_gnt_o,
  output logic    b_gnt_o
);

  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (!stall_i) begin
      if (a_req_i && (!b_req_i || (ptr_i == PRI_A))) begin
        a_gnt_o = 1'b1;
      end else if (b_req_i) begin
        b_gnt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: same-cycle ack, one-cycle registered issue,
// one-hot write enable and a wrapping count of issued writes.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                rf_stall,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ack,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ack,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic [CNT_W-1:0]    wr_count
);

  rr_ptr_e             ptr_q, ptr_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                a_gnt, b_gnt;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_data;

  rf_wr_rr_pick u_pick (
    .a_req_i (a_req),
    .b_req_i (b_req),
    .stall_i (rf_stall),
    .ptr_i   (ptr_q),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );

  // Acks are masked during reset so nothing is accepted while state is being cleared.
  assign a_ack    = a_gnt & ~ctrl_reset;
  assign b_ack    = b_gnt & ~ctrl_reset;
  assign gnt_addr = a_gnt ? a_addr : b_addr;
  assign gnt_data = a_gnt ? a_data : b_data;

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    if (a_ack || b_ack) begin
      ptr_d     = a_ack ? PRI_B : PRI_A;
      wr_data_d = gnt_data;
      if (!(ZERO_PROTECT && (gnt_addr == '0))) begin
        wr_en_d = {{(NUM_REGS-1){1'b0}}, 1'b1} << gnt_addr;
      end
    end
    // Count advances together with the issue so it is current in the issue cycle.
    if (wr_en_d != '0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ptr_q     <= PRI_A;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a behavioural model.
module tb_rf_write_arbiter;

  localparam int unsigned CNT_W = 4;
  localparam bit          ZP    = 1'b1;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        rf_stall = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ack, b_ack;
  logic [31:0] wr_en, wr_data;
  logic [CNT_W-1:0] wr_count;

  int n_pass = 0;
  int n_chk  = 0;

  rf_write_arbiter #(
    .CNT_W        (CNT_W),
    .ZERO_PROTECT (ZP)
  ) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .rf_stall   (rf_stall),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ack      (b_ack),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_count   (wr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: which requester the spec says wins, and what the register file sees.
  bit          m_turn_b;
  logic [31:0] m_en, m_data;
  int          m_cnt;

  always @(negedge clock) begin
    bit ea, eb;
    int addr;
    if (ctrl_reset) begin
      m_turn_b = 1'b0;
      m_en     = '0;
      m_data   = '0;
      m_cnt    = 0;
      chk("rst_a_ack", a_ack, 0);
      chk("rst_b_ack", b_ack, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_count", wr_count, 0);
    end else begin
      if (rf_stall)            begin ea = 0; eb = 0; end
      else if (a_req && b_req) begin ea = !m_turn_b; eb = m_turn_b; end
      else                     begin ea = a_req; eb = b_req; end
      chk("a_ack", a_ack, ea);
      chk("b_ack", b_ack, eb);
      chk("wr_en", wr_en, m_en);
      chk("wr_data", wr_data, m_data);
      chk("wr_count", wr_count, m_cnt);
      m_en = '0;
      if (ea || eb) begin
        addr     = ea ? int'(a_addr) : int'(b_addr);
        m_data   = ea ? a_data : b_data;
        m_turn_b = ea;
        if (!(ZP && addr == 0)) m_en = 32'h1 << addr;
      end
      if (m_en != 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  // Drive one cycle of inputs just after the edge; returns once acks have settled.
  task automatic cyc(input bit ar, input logic [4:0] aa, input logic [31:0] ad,
                     input bit br, input logic [4:0] ba, input logic [31:0] bd,
                     input bit st);
    @(posedge clock);
    #1;
    a_req = ar; a_addr = aa; a_data = ad;
    b_req = br; b_addr = ba; b_data = bd;
    rf_stall = st;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    a_req = 0; b_req = 0; rf_stall = 0;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    #1;
  endtask

  initial begin
    bit na, nb;
    // Reset state, with a request held high to show acks are masked.
    #1;
    a_req = 1'b1;
    #1;
    chk("lit_rst_ack_masked", a_ack, 0);
    chk("lit_rst_wr_en", wr_en, 0);
    chk("lit_rst_count", wr_count, 0);
    do_reset();

    // Single A write.
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0);
    chk("lit_a_ack", a_ack, 1);
    chk("lit_b_ack_idle", b_ack, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    chk("lit_wr_en_a5", wr_en, 32'h0000_0020);
    chk("lit_wr_data_a5", wr_data, 32'hDEADBEEF);
    chk("lit_count_1", wr_count, 1);

    // Continuous contention from reset: A,B,A,B with no bubbles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5'd1, 32'hA000 + i, 1, 5'd2, 32'hB000 + i, 0);
      chk("lit_rr_a_ack", a_ack, (i % 2) == 0);
      chk("lit_rr_b_ack", b_ack, (i % 2) == 1);
      if (i > 0) chk("lit_rr_wr_en", wr_en, ((i - 1) % 2 == 0) ? 32'h2 : 32'h4);
    end
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    chk("lit_rr_last_wr_en", wr_en, 32'h4);
    chk("lit_rr_count", wr_count, 4);

    // Register 0 is protected.
    do_reset();
    cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0);
    chk("lit_zero_b_ack", b_ack, 1);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    chk("lit_zero_wr_en", wr_en, 0);
    chk("lit_zero_wr_data", wr_data, 32'h1234);
    chk("lit_zero_count", wr_count, 0);

    // Stall holds the pointer at PRI_B; stall after an ack does not cancel that issue.
    do_reset();
    cyc(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 1);
      chk("lit_stall_a_ack", a_ack, 0);
      chk("lit_stall_b_ack", b_ack, 0);
      chk("lit_stall_wr_en", wr_en, (i == 0) ? 32'h8 : 32'h0);
    end
    cyc(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 0);
    chk("lit_post_stall_b_ack", b_ack, 1);
    chk("lit_post_stall_a_ack", a_ack, 0);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1);
    chk("lit_stall_after_ack_wr_en", wr_en, 32'h200);
    chk("lit_stall_after_ack_count", wr_count, 2);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) cyc(1, 5'd31, 32'(k), 0, 5'd0, 32'h0, 0);
      else        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
      if (k > 0) begin
        chk("lit_wrap_wr_en", wr_en, 32'h8000_0000);
        chk("lit_wrap_count", wr_count, k % 16);
      end
    end

    // Reset between the ack edge and the next edge discards the pending write.
    do_reset();
    cyc(1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 0);
    chk("lit_prerst_a_ack", a_ack, 1);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    a_req = 0; b_req = 0;
    #1;
    chk("lit_midrst_wr_en", wr_en, 0);
    chk("lit_midrst_count", wr_count, 0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    chk("lit_postrst_wr_en", wr_en, 0);
    cyc(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0);
    chk("lit_postrst_ptr_a", a_ack, 1);

    // Random traffic: held requests until ack, occasional withdrawal, random stall.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      na = a_req; nb = b_req;
      if (a_req && !a_ack) begin
        if ($urandom_range(9) == 0) na = 0;
      end else begin
        na = $urandom_range(1);
        a_addr = 5'($urandom); a_data = $urandom;
      end
      if (b_req && !b_ack) begin
        if ($urandom_range(9) == 0) nb = 0;
      end else begin
        nb = $urandom_range(1);
        b_addr = 5'($urandom); b_data = $urandom;
      end
      if ($urandom_range(7) == 0) begin
        a_addr = b_addr;
      end
      cyc(na, a_addr, a_data, nb, b_addr, b_data, $urandom_range(4) == 0);
      if (i == 700) begin
        @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        a_req = 0; b_req = 0;
        @(posedge clock);
        #1;
        ctrl_reset = 1'b0;
        #1;
      end
    end
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0);
    @(posedge clock);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
